// File: rtl/player_ctrl.sv
// ---------------------------------------------------------------------------
// player_ctrl
//
// Controls one player of a simple bat-and-ball game: it detects swing
// presses, decides whether a swing returns the ball, and tracks the player's
// remaining lives until the game is over.
//
// Optional feature macro: PLAYER_COOLDOWN_EN
//   defined   -> after every swing the player is locked out for
//                COOLDOWN_CYCLES clocks before a new swing can start
//   undefined -> a finished swing returns straight to READY
//
// Parameters
//   MAX_LIVES        lives loaded at game start (1 .. 2**LIFE_W-1)
//   LIFE_W           width of the lives output
//   SWING_CYCLES     length of the swing window in clocks (>= 1)
//   COOLDOWN_CYCLES  post-swing lockout in clocks (>= 1), cooldown build only
//
// Ports
//   clk            system clock, everything updates on the rising edge
//   rst            synchronous active-high reset, overrides start_game
//   start_game     level, high while the game runs, low holds in IDLE
//   button         raw swing button, synchronous to clk
//   hittable_ball  level, high while the ball is in this player's hit zone
//   hit            registered one-cycle pulse, ball returned
//   lives          registered remaining lives
//   match          registered level, this player is out of lives
// ---------------------------------------------------------------------------
module player_ctrl #(
    parameter int MAX_LIVES       = 3,
    parameter int LIFE_W          = 2,
    parameter int SWING_CYCLES    = 4,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_game,
    input  logic              button,
    input  logic              hittable_ball,
    output logic              hit,
    output logic [LIFE_W-1:0] lives,
    output logic              match
);

    // One shared down-counter serves both the swing window and the
    // cooldown, so it is sized for whichever of the two is longer.
    localparam int CNT_MAX = (SWING_CYCLES > COOLDOWN_CYCLES) ? SWING_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  SWING_LOAD = CNT_W'(SWING_CYCLES - 1);
    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(MAX_LIVES);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READY    = 3'd1;
    localparam logic [2:0] ST_SWING    = 3'd2;
    localparam logic [2:0] ST_OVER     = 3'd4;

    // Where a finished swing goes, and what the counter holds on arrival.
`ifdef PLAYER_COOLDOWN_EN
    localparam logic [2:0]       ST_COOLDOWN      = 3'd3;
    localparam logic [2:0]       ST_AFTER_SWING   = ST_COOLDOWN;
    localparam logic [CNT_W-1:0] AFTER_SWING_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
`else
    localparam logic [2:0]       ST_AFTER_SWING   = ST_READY;
    localparam logic [CNT_W-1:0] AFTER_SWING_LOAD = '0;
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_q;
    logic             ball_q;
    logic             returned;

    logic             press;
    logic             ball_rise;
    logic             ball_fall;
    logic             returned_eff;
    logic             in_play;
    logic             hit_now;
    logic             life_loss;

    // Edge detection against last cycle's samples. A new hittable window
    // clears the returned flag in the very cycle it opens, so a swing that
    // is already running can hit a ball that only just arrived; that is why
    // decisions use returned_eff rather than the raw flag.
    assign press        = button & ~btn_q;
    assign ball_rise    = hittable_ball & ~ball_q;
    assign ball_fall    = ~hittable_ball & ball_q;
    assign returned_eff = returned & ~ball_rise;

    // Lives can only be lost while the player is actually playing a ball,
    // never in IDLE or once the game is over.
`ifdef PLAYER_COOLDOWN_EN
    assign in_play = (state == ST_READY) || (state == ST_SWING) || (state == ST_COOLDOWN);
`else
    assign in_play = (state == ST_READY) || (state == ST_SWING);
`endif

    // A hit needs an active swing, a ball in the zone, and a ball that has
    // not already been returned in this window. A ball that leaves the zone
    // without having been returned costs a life.
    assign hit_now   = (state == ST_SWING) && hittable_ball && !returned_eff;
    assign life_loss = in_play && ball_fall && !returned_eff;

    // Main sequencer. Reset and a dropped start_game both bring the player
    // back to a fresh IDLE. Inside the game the state case handles swing
    // timing, and the life-loss check comes last so that running out of
    // lives always wins and moves straight to OVER on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            btn_q    <= 1'b0;
            ball_q   <= 1'b0;
            returned <= 1'b0;
            hit      <= 1'b0;
            lives    <= LIVES_INIT;
            match    <= 1'b0;
        end else begin
            btn_q  <= button;
            ball_q <= hittable_ball;
            hit    <= 1'b0;

            if (!start_game) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                returned <= 1'b0;
                lives    <= LIVES_INIT;
                match    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_READY;
                        cnt      <= '0;
                        returned <= 1'b0;
                        lives    <= LIVES_INIT;
                        match    <= 1'b0;
                    end

                    ST_READY: begin
                        if (press) begin
                            state <= ST_SWING;
                            cnt   <= SWING_LOAD;
                        end
                    end

                    ST_SWING: begin
                        if (hit_now || (cnt == '0)) begin
                            state <= ST_AFTER_SWING;
                            cnt   <= AFTER_SWING_LOAD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

`ifdef PLAYER_COOLDOWN_EN
                    ST_COOLDOWN: begin
                        if (cnt == '0) begin
                            state <= ST_READY;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`endif

                    ST_OVER: begin
                        state <= ST_OVER;
                    end

                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase

                if (in_play) begin
                    if (ball_rise) begin
                        returned <= 1'b0;
                    end
                    if (hit_now) begin
                        returned <= 1'b1;
                        hit      <= 1'b1;
                    end
                    if (life_loss) begin
                        if (lives <= LIFE_W'(1)) begin
                            lives <= '0;
                            match <= 1'b1;
                            state <= ST_OVER;
                            cnt   <= '0;
                        end else begin
                            lives <= lives - LIFE_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 Parameter MAX_LIVES, default 3: lives loaded at game start (1..2**LIFE_W-1).
REQ-002 Parameter LIFE_W, default 2: width of lives output.
REQ-003 Parameter SWING_CYCLES, default 4: length of swing window in clocks (>=1).
REQ-004 Parameter COOLDOWN_CYCLES, default 8: post-swing lockout in clocks (>=1), used only when PLAYER_COOLDOWN_EN is defined.
REQ-005 clk  input  1  single system clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start_game  input  1  level; high = game running, low = abort/hold in IDLE.
REQ-008 button  input  1  raw swing button, synchronous to clk.
REQ-009 hittable_ball  input  1  level; high while ball is in this player's hit zone.
REQ-010 hit  output  1  registered one-cycle pulse: ball returned.
REQ-011 lives  output  LIFE_W  remaining lives.
REQ-012 match  output  1  registered level: game over, this player out of lives.

Function
REQ-013 States SHALL be IDLE, READY, SWING, COOLDOWN, OVER; all outputs registered.
REQ-014 IDLE: lives=MAX_LIVES, match=0, hit=0; start_game=1 -> READY next cycle.
REQ-015 start_game=0 in any state SHALL force IDLE next cycle (lives reloaded, match cleared, counters cleared).
REQ-016 Press SHALL be button rising edge only (button=1, previous-cycle button=0); held button never retriggers.
REQ-017 READY + press -> SWING next cycle, swing counter loaded SWING_CYCLES-1; press in any other state ignored.
REQ-018 SWING cycle with hittable_ball=1 SHALL set hit=1 the following cycle for exactly one cycle, mark the current ball returned, and leave SWING.
REQ-019 SWING with counter=0 and no hit SHALL leave SWING (miss-swing, no life lost by itself).
REQ-020 Leaving SWING -> COOLDOWN when PLAYER_COOLDOWN_EN defined, else -> READY.
REQ-021 Ball-returned flag SHALL clear on hittable_ball rising edge; at most one hit per hittable window.
REQ-022 hittable_ball falling edge with flag clear, state in READY/SWING/COOLDOWN: lives decrements by 1 next cycle.
REQ-023 Decrement reaching 0: lives=0, match=1, state OVER same edge; lives never wraps below 0.
REQ-024 OVER: hit=0, presses and ball edges ignored; exit only via REQ-015.
REQ-025 Hit and falling edge same cycle: hittable_ball=0 so no hit; life lost per REQ-022.
REQ-026 Press in cycle where hittable_ball rises: SWING begins next cycle; hit possible from that cycle.
REQ-027 Counter widths SHALL be $clog2 of max(SWING_CYCLES, COOLDOWN_CYCLES)+1, no truncation.

Reset
REQ-028 rst=1 at a rising edge: state IDLE, hit=0, lives=MAX_LIVES, match=0, counters, edge-history registers and returned flag =0.
REQ-029 rst mid-SWING or in OVER SHALL abort identically to REQ-028; rst overrides start_game.

Configuration
REQ-030 Macro PLAYER_COOLDOWN_EN defined: COOLDOWN state present; counter loaded COOLDOWN_CYCLES-1 on entry, -> READY when 0; presses during COOLDOWN discarded.
REQ-031 PLAYER_COOLDOWN_EN undefined: no COOLDOWN state or counter logic; SWING exits straight to READY; all other behaviour unchanged.

Verification (defaults, 20 ns clock)
REQ-032 rst=1 two cycles, start_game=1 -> lives=3, match=0, hit=0; READY after first post-reset edge.
REQ-033 hittable_ball=1, one press -> hit high exactly one cycle within 1..SWING_CYCLES+1 clocks of press; lives stays 3 after hittable_ball falls.
REQ-034 hittable_ball high 3 cycles then low, no press -> lives 3->2 one cycle after fall; repeat twice -> lives=0, match=1, later presses give no hit.
REQ-035 button held high 100 cycles during hittable window -> single swing, at most one hit; with PLAYER_COOLDOWN_EN, second press 3 cycles after swing exit ignored, press after 8 cycles accepted.
REQ-036 rst asserted during SWING and in OVER -> next cycle lives=3, match=0, hit=0, state IDLE; start_game low mid-game -> same result.
